freq_meter: RTL

Gated frequency counter for slow board signals: counts rising edges of an asynchronous input over a fixed window of `GATE_COUNT` clock cycles and reports the count. It is the measuring counterpart of the clock divider. It sits beside the divider and the display logic and is used to check divided clocks, button and pulse rates, and external test signals against the 100 MHz board clock.

---
 rtl/freq_meter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - gated rising-edge counter for slow asynchronous signals
// Counts sig_in rising edges over GATE_COUNT clk_in cycles and reports the saturated count.
module freq_meter #(
    parameter int unsigned GATE_COUNT = 100_000_000,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             start,
    input  logic             cont,
    output logic [CNT_W-1:0] freq_out,
    output logic             valid,
    output logic             busy,
    output logic             ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [30:0]      GCNT_LAST = 31'(GATE_COUNT - 1);
    localparam logic [CNT_W-1:0] ECNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic             s1_q, s2_q, s3_q;
    logic             rise;
    logic [30:0]      gcnt_q, gcnt_d;
    logic [CNT_W-1:0] ecnt_q, ecnt_d;
    logic             sat_q, sat_d;
    logic [CNT_W-1:0] freq_q, freq_d;
    logic             ovf_q, ovf_d;

    // Synchronizer free-runs in every state so a level already high at gate open is not an edge.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= sig_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise = s2_q & ~s3_q;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gcnt_q  <= '0;
            ecnt_q  <= '0;
            sat_q   <= 1'b0;
            freq_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gcnt_q  <= gcnt_d;
            ecnt_q  <= ecnt_d;
            sat_q   <= sat_d;
            freq_q  <= freq_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gcnt_d  = gcnt_q;
        ecnt_d  = ecnt_q;
        sat_d   = sat_q;
        freq_d  = freq_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = GATE;
                    gcnt_d  = '0;
                    ecnt_d  = '0;
                    sat_d   = 1'b0;
                end
            end
            GATE: begin
                gcnt_d = gcnt_q + 31'd1;
                if (rise) begin
                    if (&ecnt_q) begin
                        sat_d = 1'b1;
                    end else begin
                        ecnt_d = ecnt_q + ECNT_ONE;
                    end
                end
                // Result is captured on the closing edge so freq_out is already stable while valid is high.
                if (gcnt_q == GCNT_LAST) begin
                    state_d = DONE;
                    freq_d  = ecnt_d;
                    ovf_d   = sat_d;
                end
            end
            DONE: begin
                if (cont) begin
                    state_d = GATE;
                    gcnt_d  = '0;
                    ecnt_d  = '0;
                    sat_d   = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign freq_out = freq_q;
    assign ovf      = ovf_q;
    assign valid    = (state_q == DONE);
    assign busy     = (state_q != IDLE);

endmodule
